// File: rtl/sm_to_tc_serial.sv
// Bit-serial sign-magnitude to two's-complement converter.
// One magnitude bit is processed per clock, LSB first. Negative words are
// negated with the copy-until-first-one, then invert rule. The result is
// presented behind a valid/ready handshake and held until it is taken.
module sm_to_tc_serial #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_argA,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_error
);

    localparam int MW    = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [MW-1:0]     mag_q, mag_d;
    logic [MW-1:0]     work_q, work_d;
    logic              sign_q, sign_d;
    logic              seen_q, seen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              error_q, error_d;

    logic accept;
    logic last_bit;
    logic cur_bit;
    logic conv_bit;

    assign accept   = (state_q == IDLE) && i_valid;
    assign last_bit = (state_q == CONV) && (cnt_q == CNT_LAST);
    assign cur_bit  = mag_q[0];
    // Below the first 1 the bits are copied; above it a negative word inverts.
    assign conv_bit = (sign_q && seen_q) ? ~cur_bit : cur_bit;

    // State register: async reset returns the handshake to IDLE at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CONV on accept, CONV -> DONE on the last bit,
    // DONE -> IDLE when downstream takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid)  state_d = CONV;
            CONV:    if (last_bit) state_d = DONE;
            DONE:    if (i_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshake flags come from registered state only.
    always_comb begin
        o_ready  = (state_q == IDLE);
        o_valid  = (state_q == DONE);
        o_result = result_q;
        o_error  = error_q;
    end

    // Datapath next-state: capture on accept, shift one bit per CONV cycle,
    // and load the output registers together with the final bit.
    always_comb begin
        mag_d    = mag_q;
        work_d   = work_q;
        sign_d   = sign_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        if (accept) begin
            mag_d  = i_argA[WIDTH-2:0];
            sign_d = i_argA[WIDTH-1];
            seen_d = 1'b0;
            cnt_d  = '0;
            work_d = '0;
        end else if (state_q == CONV) begin
            mag_d          = mag_q >> 1;
            work_d         = work_q >> 1;
            work_d[MW-1]   = conv_bit;
            seen_d         = seen_q | cur_bit;
            if (last_bit) begin
                // Final seen flag doubles as "magnitude is nonzero".
                result_d = {sign_q & seen_d, work_d};
                error_d  = sign_q & ~seen_d;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers: cleared by reset so a partial result never leaks out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag_q    <= '0;
            work_q   <= '0;
            sign_q   <= 1'b0;
            seen_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            mag_q    <= mag_d;
            work_q   <= work_d;
            sign_q   <= sign_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_sm_to_tc_serial.sv
// Testbench for sm_to_tc_serial: an 8-bit and a 32-bit instance driven from
// a table of directed vectors, plus backpressure and mid-conversion reset.
module tb_sm_to_tc_serial;

    logic        clk;
    logic        rst_n;
    logic        i_ready;

    logic        valid8;
    logic [7:0]  argA8;
    logic        ordy8, ovld8, oerr8;
    logic [7:0]  ores8;

    logic        valid32;
    logic [31:0] argA32;
    logic        ordy32, ovld32, oerr32;
    logic [31:0] ores32;

    int checks;
    int failures;

    sm_to_tc_serial #(.WIDTH(8)) dut8 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid8),
        .o_ready  (ordy8),
        .i_argA   (argA8),
        .o_valid  (ovld8),
        .i_ready  (i_ready),
        .o_result (ores8),
        .o_error  (oerr8)
    );

    sm_to_tc_serial #(.WIDTH(32)) dut32 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid32),
        .o_ready  (ordy32),
        .i_argA   (argA32),
        .o_valid  (ovld32),
        .i_ready  (i_ready),
        .o_result (ores32),
        .o_error  (oerr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] res;
        logic        err;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic get_vld(input int w);
        return (w == 8) ? ovld8 : ovld32;
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 8) ? ordy8 : ordy32;
    endfunction

    function automatic logic [31:0] get_res(input int w);
        return (w == 8) ? {24'd0, ores8} : ores32;
    endfunction

    function automatic logic get_err(input int w);
        return (w == 8) ? oerr8 : oerr32;
    endfunction

    // Waits (bounded) for o_valid after an accept edge; returns edges elapsed.
    task automatic wait_valid(input int w, output int n);
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(posedge clk);
            #1;
            n++;
            got = get_vld(w);
        end
    endtask

    // Full transaction: accept, check latency/result/error, hand off, check IDLE.
    task automatic convert(input int w, input logic [31:0] a, input logic [31:0] res,
                           input logic err, input string nm);
        int n;
        @(negedge clk);
        chk({nm, " ready_before"}, 32'(get_rdy(w)), 32'd1);
        if (w == 8) begin
            valid8 = 1'b1;
            argA8  = a[7:0];
        end else begin
            valid32 = 1'b1;
            argA32  = a;
        end
        @(posedge clk);
        #1;
        valid8  = 1'b0;
        valid32 = 1'b0;
        argA8   = 8'hAA;
        argA32  = 32'hDEADBEEF;
        wait_valid(w, n);
        chk({nm, " latency"}, 32'(n), 32'(w - 1));
        chk({nm, " result"}, get_res(w), res);
        chk({nm, " error"}, 32'(get_err(w)), 32'(err));
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk({nm, " valid_after_take"}, 32'(get_vld(w)), 32'd0);
        chk({nm, " ready_after_take"}, 32'(get_rdy(w)), 32'd1);
        chk({nm, " result_held"}, get_res(w), res);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_ready  = 1'b0;
        valid8   = 1'b0;
        valid32  = 1'b0;
        argA8    = '0;
        argA32   = '0;

        vecs.push_back('{8,  32'h05,       32'h05,       1'b0, "w8_05"});
        vecs.push_back('{8,  32'h7F,       32'h7F,       1'b0, "w8_7F"});
        vecs.push_back('{8,  32'h85,       32'hFB,       1'b0, "w8_85"});
        vecs.push_back('{8,  32'hFF,       32'h81,       1'b0, "w8_FF"});
        vecs.push_back('{8,  32'h81,       32'hFF,       1'b0, "w8_81"});
        vecs.push_back('{8,  32'h80,       32'h00,       1'b1, "w8_80_negzero"});
        vecs.push_back('{8,  32'h00,       32'h00,       1'b0, "w8_00"});
        vecs.push_back('{8,  32'hC0,       32'hC0,       1'b0, "w8_C0"});
        vecs.push_back('{32, 32'h80000001, 32'hFFFFFFFF, 1'b0, "w32_80000001"});
        vecs.push_back('{32, 32'hFFFFFFFF, 32'h80000001, 1'b0, "w32_FFFFFFFF"});
        vecs.push_back('{32, 32'h12345678, 32'h12345678, 1'b0, "w32_12345678"});
        vecs.push_back('{32, 32'h80000000, 32'h00000000, 1'b1, "w32_negzero"});

        // Reset state
        #12;
        chk("rst ready8",  32'(ordy8),  32'd1);
        chk("rst valid8",  32'(ovld8),  32'd0);
        chk("rst result8", 32'(ores8),  32'd0);
        chk("rst error8",  32'(oerr8),  32'd0);
        chk("rst ready32", 32'(ordy32), 32'd1);
        chk("rst valid32", 32'(ovld32), 32'd0);
        chk("rst result32", ores32,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            convert(vecs[i].w, vecs[i].a, vecs[i].res, vecs[i].err, vecs[i].nm);

        // Backpressure: hold in DONE while i_valid toggles with changing data
        @(negedge clk);
        valid8 = 1'b1;
        argA8  = 8'h85;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        wait_valid(8, n);
        chk("bp latency", 32'(n), 32'd7);
        valid8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            argA8 = 8'(8'h11 * (c + 1));
            @(posedge clk);
            #1;
            chk("bp valid_held", 32'(ovld8), 32'd1);
            chk("bp ready_low",  32'(ordy8), 32'd0);
            chk("bp result",     32'(ores8), 32'hFB);
            chk("bp error",      32'(oerr8), 32'd0);
        end
        argA8   = 8'h83;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("bp idle ready", 32'(ordy8), 32'd1);
        chk("bp idle valid", 32'(ovld8), 32'd0);
        chk("bp idle result", 32'(ores8), 32'hFB);
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        argA8  = 8'h00;
        chk("bp next accepted", 32'(ordy8), 32'd0);
        wait_valid(8, n);
        chk("bp next latency", 32'(n), 32'd7);
        chk("bp next result",  32'(ores8), 32'hFD);
        chk("bp next error",   32'(oerr8), 32'd0);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;

        // Reset asserted mid-conversion
        @(negedge clk);
        valid8 = 1'b1;
        argA8  = 8'h85;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid in_conv", 32'(ordy8), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstmid valid",  32'(ovld8), 32'd0);
        chk("rstmid result", 32'(ores8), 32'd0);
        chk("rstmid ready",  32'(ordy8), 32'd1);
        chk("rstmid error",  32'(oerr8), 32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ovld8 !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL rstmid no_valid: got %0b expected 0", ovld8);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        convert(8, 32'h85, 32'hFB, 1'b0, "post_rst_85");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
